// File: rtl/seq_stim_gen.sv
`default_nettype none
// ============================================================================
//  Module   : seq_stim_gen
//  Purpose  : Sequence stimulus generator. Operand vectors are queued in a
//             4-entry FIFO, then played back one at a time on seq1/seq2/seq3.
//             Each vector is held for HOLD_CYCLES cycles. The downstream
//             result (seq_in) is then captured into res_data, and res_valid
//             pulses for one cycle.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1   clock, rising edge
//    rst        in   1   asynchronous active-high reset
//    wr_en      in   1   push wr_data into the vector buffer
//    wr_data    in  12   {seq1[11:8], seq2[7:4], seq3[3:0]}
//    full       out  1   vector buffer holds DEPTH entries
//    start      in   1   begin playback (ignored when buffer empty or busy)
//    seq1..3    out  4   operand vectors to the downstream block
//    seq_in     in   8   downstream result for the current vectors
//    res_valid  out  1   one-cycle pulse, res_data holds a new result
//    res_data   out  8   captured result
//    busy       out  1   playback in progress
//    done       out  1   one-cycle pulse when playback ends
// ============================================================================
module seq_stim_gen #(
  parameter int HOLD_CYCLES = 2,
  parameter int DEPTH       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [11:0] wr_data,
  output logic        full,
  input  logic        start,
  output logic [3:0]  seq1,
  output logic [3:0]  seq2,
  output logic [3:0]  seq3,
  input  logic [7:0]  seq_in,
  output logic        res_valid,
  output logic [7:0]  res_data,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);
  localparam logic [2:0] FULL_CNT  = 3'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      state;
  logic [11:0] mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;
  logic [3:0]  hold_cnt;
  logic        empty;
  logic        pop;
  logic        push;
  logic [11:0] head;

  assign full  = (count == FULL_CNT);
  assign empty = (count == 3'd0);
  assign head  = mem[rd_ptr];
  assign busy  = (state == ST_DRIVE);

  // Pops happen on a start from IDLE, or when a vector's hold expires.
  assign pop  = !empty && (((state == ST_IDLE) && start) ||
                           ((state == ST_DRIVE) && (hold_cnt == 4'd0)));
  // A pop in the same cycle frees the slot, so a write to a full buffer
  // is accepted then. When full, wr_ptr == rd_ptr. The head is read
  // before the overwrite lands.
  assign push = wr_en && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      hold_cnt  <= 4'd0;
      seq1      <= 4'd0;
      seq2      <= 4'd0;
      seq3      <= 4'd0;
      res_data  <= 8'd0;
      res_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            {seq1, seq2, seq3} <= head;
            hold_cnt           <= HOLD_LOAD;
            state              <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (hold_cnt != 4'd0) begin
            hold_cnt <= hold_cnt - 4'd1;
          end else begin
            res_data  <= seq_in;
            res_valid <= 1'b1;
            if (pop) begin
              {seq1, seq2, seq3} <= head;
              hold_cnt           <= HOLD_LOAD;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          // done is registered, so it lands one cycle after the last result.
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_stim_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_stim_gen
//  Purpose  : Self-checking bench for seq_stim_gen (HOLD_CYCLES=2 and =1)
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_stim_gen;

  typedef struct {
    logic [11:0] wdata;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [3:0]  s3;
    logic [7:0]  res;
  } vec_t;

  typedef struct {
    logic [11:0] vec;
    logic [7:0]  res;
  } exp_t;

  logic        clk;
  logic        rst;
  // instance A: HOLD_CYCLES = 2
  logic        wr_en, start, full, res_valid, busy, done;
  logic [11:0] wr_data;
  logic [3:0]  seq1, seq2, seq3;
  logic [7:0]  seq_in, res_data;
  // instance B: HOLD_CYCLES = 1
  logic        wr_en_b, start_b, full_b, res_valid_b, busy_b, done_b;
  logic [11:0] wr_data_b;
  logic [3:0]  seq1_b, seq2_b, seq3_b;
  logic [7:0]  seq_in_b, res_data_b;

  int   vec_count = 0;
  int   err_count = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [11:0] prev_seq;
  vec_t tbl [3];

  // Downstream operations block model
  assign seq_in   = {seq1 ^ seq2, seq3};
  assign seq_in_b = {seq1_b ^ seq2_b, seq3_b};

  seq_stim_gen #(.HOLD_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .start(start), .seq1(seq1), .seq2(seq2), .seq3(seq3), .seq_in(seq_in),
    .res_valid(res_valid), .res_data(res_data), .busy(busy), .done(done)
  );

  seq_stim_gen #(.HOLD_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en_b), .wr_data(wr_data_b), .full(full_b),
    .start(start_b), .seq1(seq1_b), .seq2(seq2_b), .seq3(seq3_b), .seq_in(seq_in_b),
    .res_valid(res_valid_b), .res_data(res_data_b), .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model_res(input logic [11:0] v);
    return {v[11:8] ^ v[7:4], v[3:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      err_count++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_vec(input logic [11:0] d, input bit accepted);
    exp_t e;
    wr_en   = 1'b1;
    wr_data = d;
    if (accepted) begin
      e.vec = d;
      e.res = model_res(d);
      exp_q.push_back(e);
    end
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int nres, output bit seen);
    nres = 0;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      tick();
      if (res_valid) nres++;
      if (done) seen = 1'b1;
    end
  endtask

  // Scoreboard: every result from instance A must match the oldest accepted write.
  always @(negedge clk) begin
    if (res_valid) begin
      if (exp_q.size() == 0) begin
        vec_count++;
        err_count++;
        $display("FAIL unexpected_res_valid: got res_data %0h, required no result pending", res_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("res_data", {24'd0, res_data}, {24'd0, mon_e.res});
        check("played_vector", {20'd0, prev_seq}, {20'd0, mon_e.vec});
      end
    end
    prev_seq = {seq1, seq2, seq3};
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    int  nres;
    bit  seen;

    tbl[0] = '{12'hB3A, 4'hB, 4'h3, 4'hA, 8'h8A};
    tbl[1] = '{12'hCD8, 4'hC, 4'hD, 4'h8, 8'h18};
    tbl[2] = '{12'h03C, 4'h0, 4'h3, 4'hC, 8'h3C};

    wr_en = 0; wr_data = 0; start = 0;
    wr_en_b = 0; wr_data_b = 0; start_b = 0;
    rst = 1'b1;
    prev_seq = 12'd0;

    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_full", full, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_seq", {seq1, seq2, seq3}, 0);
    check("rst_res_data", res_data, 0);
    check("rst_b_outputs", {full_b, busy_b, done_b, res_valid_b, seq1_b, seq2_b, seq3_b, res_data_b}, 0);
    rst = 1'b0;

    // ---------------- basic playback (table driven) ----------------
    for (int i = 0; i < 3; i++) write_vec(tbl[i].wdata, 1'b1);
    check("basic_full", full, 0);
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      for (int h = 0; h < 2; h++) begin
        if (!(i == 0 && h == 0)) tick();
        check($sformatf("basic_seq_v%0d_h%0d", i, h), {seq1, seq2, seq3}, {tbl[i].s1, tbl[i].s2, tbl[i].s3});
        check($sformatf("basic_rv_v%0d_h%0d", i, h), res_valid, (i > 0 && h == 0));
        check($sformatf("basic_busy_v%0d_h%0d", i, h), busy, 1);
      end
    end
    tick();
    check("basic_last_rv", res_valid, 1);
    check("basic_busy_off", busy, 0);
    check("basic_done_early", done, 0);
    tick();
    check("basic_done_pulse", done, 1);
    check("basic_rv_off", res_valid, 0);
    tick();
    check("basic_done_once", done, 0);
    check("basic_seq_hold", {seq1, seq2, seq3}, {tbl[2].s1, tbl[2].s2, tbl[2].s3});
    check("basic_drain", exp_q.size(), 0);

    // ---------------- empty start ----------------
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("empty_quiet_%0d", k), {busy, res_valid, done}, 0);
      tick();
    end

    // ---------------- overflow ----------------
    write_vec(12'h111, 1'b1);
    write_vec(12'h222, 1'b1);
    write_vec(12'h345, 1'b1);
    check("ovf_full_3", full, 0);
    write_vec(12'h9A7, 1'b1);
    check("ovf_full_4", full, 1);
    write_vec(12'hFFF, 1'b0);
    check("ovf_full_5", full, 1);
    pulse_start();
    wait_done(40, nres, seen);
    check("ovf_done_seen", seen, 1);
    check("ovf_result_count", nres, 4);
    check("ovf_drain", exp_q.size(), 0);

    // ---------------- simultaneous push / pop ----------------
    write_vec(12'h1E2, 1'b1);
    write_vec(12'h3C4, 1'b1);
    write_vec(12'h5A6, 1'b1);
    write_vec(12'h787, 1'b1);
    check("sim_full_pre", full, 1);
    pulse_start();
    check("sim_full_after_pop", full, 0);
    write_vec(12'hE5D, 1'b1);
    check("sim_full_refill", full, 1);
    write_vec(12'h6B9, 1'b1);
    check("sim_full_pushpop", full, 1);
    check("sim_rv_pushpop", res_valid, 1);
    wait_done(60, nres, seen);
    check("sim_done_seen", seen, 1);
    check("sim_result_count", nres, 5);
    check("sim_drain", exp_q.size(), 0);

    // ---------------- reset mid-run ----------------
    write_vec(12'h4A1, 1'b1);
    write_vec(12'h7C2, 1'b1);
    write_vec(12'h2D3, 1'b1);
    pulse_start();
    tick();
    tick();
    tick();
    check("mid_in_v2_hold", {seq1, seq2, seq3}, 12'h7C2);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_outputs", {full, busy, done, res_valid, seq1, seq2, seq3, res_data}, 0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("mid_quiet_%0d", k), {busy, done, res_valid, full}, 0);
      tick();
    end
    write_vec(12'h5C3, 1'b1);
    pulse_start();
    wait_done(20, nres, seen);
    check("mid_done_seen", seen, 1);
    check("mid_result_count", nres, 1);
    check("mid_drain", exp_q.size(), 0);

    // ---------------- HOLD_CYCLES = 1 ----------------
    for (int i = 0; i < 3; i++) begin
      wr_en_b = 1'b1;
      wr_data_b = tbl[i].wdata;
      tick();
    end
    wr_en_b = 1'b0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("h1_seq_v0", {seq1_b, seq2_b, seq3_b}, {tbl[0].s1, tbl[0].s2, tbl[0].s3});
    check("h1_rv_first", res_valid_b, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i < 2) begin
        check($sformatf("h1_seq_v%0d", i + 1), {seq1_b, seq2_b, seq3_b},
              {tbl[i + 1].s1, tbl[i + 1].s2, tbl[i + 1].s3});
      end
      check($sformatf("h1_rv_%0d", i), res_valid_b, 1);
      check($sformatf("h1_res_%0d", i), res_data_b, tbl[i].res);
    end
    check("h1_busy_off", busy_b, 0);
    tick();
    check("h1_done", done_b, 1);
    check("h1_rv_off", res_valid_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
`default_nettype wire
